serial_and_16: RTL and testbench
================================

SERIAL_AND_16 -- requirements
Module: serial_and_16

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and result width in bits; only 16 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin one operation.
REQ-005 SHALL have port a  input  16  operand A; sampled only when start is accepted.
REQ-006 SHALL have port b  input  16  operand B; sampled only when start is accepted.
REQ-007 SHALL have port op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NAND; sampled with a/b.
REQ-008 SHALL have port busy  output  1  high while bits are being processed.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking result completion.
REQ-010 SHALL have port out  output  16  result word, held until the next completion.

Function
REQ-011 SHALL implement states IDLE, RUN, DONE.
REQ-012 SHALL accept start only in IDLE or DONE; start in RUN is ignored, with no effect on the current operation.
REQ-013 On an accepted start at edge k, SHALL latch a, b and op into shift registers, clear the bit counter, and enter RUN.
REQ-014 In RUN, SHALL process exactly one bit per cycle, LSB first.
REQ-015 For each RUN bit, SHALL compute the 1-bit result of the latched op and shift it into a result shift register from the MSB side.
REQ-016 SHALL process bits 0..15 on edges k+1..k+16 and enter DONE at edge k+16.
REQ-017 SHALL load out with the full 16-bit result at edge k+16, so done=1 and out are valid together in the cycle following edge k+16.
REQ-018 SHALL make total latency 16 cycles from the accepting edge to the edge at which done asserts.
REQ-019 SHALL drive busy=1 exactly while in RUN; done=1 exactly while in DONE.
REQ-020 DONE SHALL last one cycle, then go to IDLE, or to RUN if start=1 in that cycle (back-to-back, no bubble).
REQ-021 SHALL wrap the bit counter 15->0 only on leaving RUN, never mid-word.
REQ-022 out SHALL NOT change except at completion or reset; a, b and op changes after acceptance SHALL NOT affect the result.

Reset
REQ-023 reset=1 at a rising edge SHALL force state IDLE, busy=0, done=0, out=16'h0000, counter=0 and shift registers=0.
REQ-024 reset SHALL take priority over start.
REQ-025 reset mid-RUN SHALL abort the operation with no done pulse and out=0.

Configuration
REQ-026 SHALL support macro SERIAL_LOGIC_OPS_EN.
REQ-027 When SERIAL_LOGIC_OPS_EN is defined, SHALL honour all four op codes.
REQ-028 When SERIAL_LOGIC_OPS_EN is undefined, SHALL always perform AND, ignore op, and have no op register.

Structure
REQ-029 SHALL place op encodings (OP_AND, OP_OR, OP_XOR, OP_NAND), state encodings and WIDTH in shared package logic_pkg.
REQ-030 SHALL instantiate one sub-module bit_logic_1, a combinational 1-bit cell (a_bit, b_bit, op -> r_bit) built from nand_0 gates, for the per-bit operation.

Verification
REQ-031 Bench SHALL check: a=FFFF, b=00FF, op=AND, start at edge k -> busy edges k+1..k+16, done cycle after k+16, out=00FF.
REQ-032 Bench SHALL check: with SERIAL_LOGIC_OPS_EN defined, a=A5A5, b=0F0F, ops OR/XOR/NAND -> out=AFAF, AAAA, FAFA respectively.
REQ-033 Bench SHALL check: start pulsed at RUN cycle 5 with a=0000 -> ignored, first result unchanged, exactly one done pulse.
REQ-034 Bench SHALL check: start held high across DONE with new a=1234, b=FFFF -> second done exactly 17 cycles after the first, out=1234.
REQ-035 Bench SHALL check: reset asserted at RUN cycle 8 -> next cycle busy=0, done=0, out=0000, and no done pulse follows.
REQ-036 Bench SHALL check: with SERIAL_LOGIC_OPS_EN undefined, a=F0F0, b=FF00, op=XOR -> out=F000 (AND).

Source files
------------

// File: rtl/logic_pkg.sv
// Shared definitions for the serial 16-bit logic unit: width, op codes, FSM states.
package logic_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/bit_logic_1.sv
// Combinational 1-bit logic cell, built only from NAND gates.
// op selects AND / OR / XOR / NAND of a_bit and b_bit.
module bit_logic_1 (
  input  logic       a_bit,
  input  logic       b_bit,
  input  logic [1:0] op,
  output logic       r_bit
);

  wire n_ab, n_a, n_b;
  wire r_and, r_or, x_a, x_b, r_xor;
  wire n_s0, n_s1;
  wire t_and, t_or, t_xor, t_nand;
  wire r_w;

  nand nand_0  (n_ab,  a_bit, b_bit);
  nand nand_1  (n_a,   a_bit, a_bit);
  nand nand_2  (n_b,   b_bit, b_bit);
  nand nand_3  (r_and, n_ab,  n_ab);
  nand nand_4  (r_or,  n_a,   n_b);
  nand nand_5  (x_a,   a_bit, n_ab);
  nand nand_6  (x_b,   b_bit, n_ab);
  nand nand_7  (r_xor, x_a,   x_b);

  // Each selected term is the inverted result; unselected terms sit at 1,
  // so the final NAND restores the chosen function.
  nand nand_8  (n_s0,   op[0], op[0]);
  nand nand_9  (n_s1,   op[1], op[1]);
  nand nand_10 (t_and,  r_and, n_s1,  n_s0);
  nand nand_11 (t_or,   r_or,  n_s1,  op[0]);
  nand nand_12 (t_xor,  r_xor, op[1], n_s0);
  nand nand_13 (t_nand, n_ab,  op[1], op[0]);
  nand nand_14 (r_w,    t_and, t_or,  t_xor, t_nand);

  assign r_bit = r_w;

endmodule

// File: rtl/serial_and_16.sv
// Bit-serial 16-bit logic unit: one bit per cycle, LSB first, result in 16 cycles.
// Define SERIAL_LOGIC_OPS_EN to honour op (AND/OR/XOR/NAND); otherwise always AND.
module serial_and_16
  import logic_pkg::*;
#(
  parameter int WIDTH = logic_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [CNT_W-1:0] cnt;
  logic             accept, last_bit, r_bit;
  logic [1:0]       op_eff;

  assign accept   = start && (state != RUN);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_LOGIC_OPS_EN
  op_t op_r;

  always_ff @(posedge clk) begin
    if (reset)
      op_r <= OP_AND;
    else if (accept)
      op_r <= op_t'(op);
  end

  assign op_eff = op_r;
`else
  assign op_eff = OP_AND;
`endif

  bit_logic_1 u_bit_logic (
    .a_bit (a_sr[0]),
    .b_bit (b_sr[0]),
    .op    (op_eff),
    .r_bit (r_bit)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Result bits enter from the MSB side so bit 0 lands at the LSB after 16 shifts.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      out    <= '0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      res_sr <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {r_bit, res_sr[WIDTH-1:1]};
      if (last_bit) begin
        out <= {r_bit, res_sr[WIDTH-1:1]};
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_and_16.sv
// Self-checking bench for serial_and_16 against a word-level reference model.
// Op-specific scenarios follow SERIAL_LOGIC_OPS_EN, matching the RTL build.
module tb_serial_and_16;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] a, b;
  logic [1:0]  op;
  logic        busy, done;
  logic [15:0] out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  serial_and_16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .op    (op),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic [1:0] o);
`ifdef SERIAL_LOGIC_OPS_EN
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x & y);
    endcase
`else
    return x & y;
`endif
  endfunction

  // Returns at the negedge after the accepting edge, with inputs scrambled.
  task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic [1:0] ov);
    @(negedge clk);
    start = 1'b1; a = av; b = bv; op = ov;
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); op = 2'($urandom);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; op = 2'b00;
    repeat (2) @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
    total_cnt++; if (out !== 16'h0000) $display("FAIL reset_out: got %h expected 0000", out); else pass_cnt++;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_and_basic;
    launch(16'hFFFF, 16'h00FF, 2'b00);
    for (int i = 0; i < 16; i++) begin
      total_cnt++;
      if ({busy, done} !== 2'b10) $display("FAIL basic_busy_c%0d: got busy/done %b%b expected 10", i, busy, done);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++; if ({busy, done} !== 2'b01) $display("FAIL basic_done: got busy/done %b%b expected 01", busy, done); else pass_cnt++;
    total_cnt++; if (out !== 16'h00FF) $display("FAIL basic_out: got %h expected 00ff", out); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b expected 0", done); else pass_cnt++;
  endtask

`ifdef SERIAL_LOGIC_OPS_EN
  task automatic test_ops;
    logic [1:0]  ops  [3] = '{2'b01, 2'b10, 2'b11};
    logic [15:0] exps [3] = '{16'hAFAF, 16'hAAAA, 16'hFAFA};
    int n;
    for (int i = 0; i < 3; i++) begin
      launch(16'hA5A5, 16'h0F0F, ops[i]);
      wait_done(n);
      total_cnt++; if (n !== 16) $display("FAIL ops_latency_%0d: got %0d expected 16", i, n); else pass_cnt++;
      total_cnt++; if (out !== exps[i]) $display("FAIL ops_out_%0d: got %h expected %h", i, out, exps[i]); else pass_cnt++;
    end
  endtask
`else
  task automatic test_and_only;
    int n;
    launch(16'hF0F0, 16'hFF00, 2'b10);
    wait_done(n);
    total_cnt++; if (n !== 16) $display("FAIL andonly_latency: got %0d expected 16", n); else pass_cnt++;
    total_cnt++; if (out !== 16'hF000) $display("FAIL andonly_out: got %h expected f000", out); else pass_cnt++;
  endtask
`endif

  task automatic test_start_ignored;
    logic [15:0] exp_out, got_out;
    int ndone, first_i;
    exp_out = model(16'hC3C3, 16'h5A5A, 2'b00);
    got_out = 16'h0; ndone = 0; first_i = -1;
    launch(16'hC3C3, 16'h5A5A, 2'b00);
    for (int i = 0; i < 40; i++) begin
      if (i == 4) begin start = 1'b1; a = 16'h0000; end
      if (i == 5) start = 1'b0;
      if (done) begin
        ndone++;
        if (first_i < 0) begin first_i = i; got_out = out; end
      end
      @(negedge clk);
    end
    total_cnt++; if (ndone !== 1) $display("FAIL ignore_pulses: got %0d expected 1", ndone); else pass_cnt++;
    total_cnt++; if (first_i !== 16) $display("FAIL ignore_latency: got %0d expected 16", first_i); else pass_cnt++;
    total_cnt++; if (got_out !== exp_out) $display("FAIL ignore_out: got %h expected %h", got_out, exp_out); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] first_exp;
    int n, n2;
    first_exp = model(16'h8421, 16'hF0F0, 2'b00);
    launch(16'h8421, 16'hF0F0, 2'b00);
    repeat (9) @(negedge clk);
    start = 1'b1; a = 16'h1234; b = 16'hFFFF; op = 2'b00;
    wait_done(n);
    total_cnt++; if (out !== first_exp) $display("FAIL b2b_first_out: got %h expected %h", out, first_exp); else pass_cnt++;
    @(negedge clk);
    n2 = 1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom);
    total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_no_bubble: got busy %b expected 1", busy); else pass_cnt++;
    total_cnt++; if (out !== first_exp) $display("FAIL b2b_out_held: got %h expected %h", out, first_exp); else pass_cnt++;
    while (!done && n2 < 40) begin
      @(negedge clk);
      n2++;
    end
    total_cnt++; if (n2 !== 17) $display("FAIL b2b_spacing: got %0d expected 17", n2); else pass_cnt++;
    total_cnt++; if (out !== 16'h1234) $display("FAIL b2b_second_out: got %h expected 1234", out); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run;
    int ndone;
    launch(16'hFFFF, 16'hFFFF, 2'b00);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL midreset_done: got %b expected 0", done); else pass_cnt++;
    total_cnt++; if (out !== 16'h0000) $display("FAIL midreset_out: got %h expected 0000", out); else pass_cnt++;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    total_cnt++; if (ndone !== 0) $display("FAIL midreset_no_done: got %0d pulses expected 0", ndone); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL midreset_stay_idle: got %b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_random;
    logic [15:0] ra, rb, exp_out;
    logic [1:0]  ro;
    int n;
    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); ro = 2'($urandom);
      exp_out = model(ra, rb, ro);
      launch(ra, rb, ro);
      wait_done(n);
      total_cnt++; if (n !== 16) $display("FAIL rand_latency_%0d: got %0d expected 16", i, n); else pass_cnt++;
      total_cnt++;
      if (out !== exp_out) $display("FAIL rand_out_%0d: a=%h b=%h op=%0d got %h expected %h", i, ra, rb, ro, out, exp_out);
      else pass_cnt++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
    test_reset;
    test_and_basic;
`ifdef SERIAL_LOGIC_OPS_EN
    test_ops;
`else
    test_and_only;
`endif
    test_start_ignored;
    test_back_to_back;
    test_reset_mid_run;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
